// File: rtl/video_pkg.sv
// Shared constants for the video framebuffer: write-mode encodings and
// clear-sequencer state encoding.
package video_pkg;

    localparam logic [1:0] WM_WRITE  = 2'b00;
    localparam logic [1:0] WM_SET    = 2'b01;
    localparam logic [1:0] WM_CLR    = 2'b10;
    localparam logic [1:0] WM_TOGGLE = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/fb_clear_seq.sv
// Clear sequencer: sweeps every cell address once after reset or on request,
// and gates the write port while the sweep runs.
module fb_clear_seq
    import video_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_start,
    output logic          busy,
    output logic [AW-1:0] clr_addr,
    output logic          clr_we
);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;

    // Next-state: a request during the sweep is ignored so it never restarts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_CLEAR: begin
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            ST_IDLE: begin
                if (clr_start) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/video_framebuffer.sv
// Parametrised pixel framebuffer with a read-modify-write write port,
// a registered read port and a sequential clear engine.
module video_framebuffer
    import video_pkg::*;
#(
    parameter  int unsigned COLS  = 16,
    parameter  int unsigned ROWS  = 16,
    parameter  int unsigned BPP   = 1,
    localparam int unsigned XW    = $clog2(COLS),
    localparam int unsigned YW    = $clog2(ROWS),
    localparam int unsigned DEPTH = COLS * ROWS,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [XW-1:0]  wr_x,
    input  logic [YW-1:0]  wr_y,
    input  logic [1:0]     wr_mode,
    input  logic [BPP-1:0] wr_data,
    input  logic           rd_en,
    input  logic [XW-1:0]  rd_x,
    input  logic [YW-1:0]  rd_y,
    output logic [BPP-1:0] rd_data,
    output logic           rd_valid,
    input  logic           clr_start,
    output logic           busy
);

    logic [BPP-1:0] mem [DEPTH];

    logic [AW-1:0]  clr_addr;
    logic           clr_we;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  rd_addr;
    logic           wr_in_range;
    logic           rd_in_range;
    logic           wr_fire;
    logic [BPP-1:0] wr_cur;
    logic [BPP-1:0] wr_new;

    fb_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_addr  (clr_addr),
        .clr_we    (clr_we)
    );

    // Ready depends on sequencer state only, never on the request inputs.
    assign wr_ready = ~busy;

    // Range checks are done at 32 bits so they stay meaningful for power-of-two sizes.
    assign wr_in_range = (32'(wr_x) < COLS) && (32'(wr_y) < ROWS);
    assign rd_in_range = (32'(rd_x) < COLS) && (32'(rd_y) < ROWS);
    assign wr_addr     = AW'(wr_y) * AW'(COLS) + AW'(wr_x);
    assign rd_addr     = AW'(rd_y) * AW'(COLS) + AW'(rd_x);
    assign wr_fire     = wr_valid && wr_ready && wr_in_range;
    assign wr_cur      = mem[wr_addr];

    always_comb begin
        wr_new = wr_cur;
        case (wr_mode)
            WM_WRITE:  wr_new = wr_data;
            WM_SET:    wr_new = wr_cur | wr_data;
            WM_CLR:    wr_new = wr_cur & ~wr_data;
            WM_TOGGLE: wr_new = wr_cur ^ wr_data;
            default:   wr_new = wr_cur;
        endcase
    end

    // Storage: the sweep and the write port are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_new;
        end
    end

    // Read register returns pre-write data and masks the array during a sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= (busy || !rd_in_range) ? BPP'(0) : mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_video_framebuffer.sv
// Scoreboard bench for video_framebuffer (10x12, 4 bpp): a behavioural model
// predicts read data, pushed on rd_en and popped when rd_valid appears.
module tb_video_framebuffer;

    localparam int COLS  = 10;
    localparam int ROWS  = 12;
    localparam int BPP   = 4;
    localparam int DEPTH = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [3:0] wr_x = '0;
    logic [3:0] wr_y = '0;
    logic [1:0] wr_mode = '0;
    logic [3:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_x = '0;
    logic [3:0] rd_y = '0;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       clr_start = 1'b0;
    logic       busy;

    video_framebuffer #(.COLS(COLS), .ROWS(ROWS), .BPP(BPP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_mode   (wr_mode),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .clr_start (clr_start),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] model [DEPTH];
    bit         m_busy = 1'b1;
    int         m_cnt = 0;
    logic [3:0] sb [$];
    logic [3:0] last_rd = '0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: predict, advance the model, clock the DUT, compare.
    task automatic tick();
        bit         sent;
        logic [3:0] exp;
        int         a;
        sent = 1'b0;
        if (rst_n && rd_en) begin
            if (m_busy || rd_x >= COLS || rd_y >= ROWS) exp = 4'd0;
            else exp = model[int'(rd_y) * COLS + int'(rd_x)];
            sb.push_back(exp);
            sent = 1'b1;
        end
        if (!rst_n) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else if (m_busy) begin
            model[m_cnt] = 4'd0;
            if (m_cnt == DEPTH - 1) m_busy = 1'b0;
            else m_cnt++;
        end else begin
            if (wr_valid && wr_x < COLS && wr_y < ROWS) begin
                a = int'(wr_y) * COLS + int'(wr_x);
                case (wr_mode)
                    2'b00: model[a] = wr_data;
                    2'b01: model[a] = model[a] | wr_data;
                    2'b10: model[a] = model[a] & ~wr_data;
                    default: model[a] = model[a] ^ wr_data;
                endcase
            end
            if (clr_start) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
        @(posedge clk);
        #1;
        check("busy", busy, m_busy);
        check("wr_ready", wr_ready, !m_busy);
        if (!rst_n) begin
            check("rst_rd_valid", rd_valid, 0);
            check("rst_rd_data", rd_data, 0);
            sb.delete();
            last_rd = 4'd0;
        end else begin
            check("rd_valid", rd_valid, sent);
            if (rd_valid && sb.size() > 0) begin
                exp = sb.pop_front();
                check("rd_data", rd_data, exp);
                last_rd = exp;
            end else if (!rd_valid) begin
                check("rd_hold", rd_data, last_rd);
            end
        end
    endtask

    task automatic quiet();
        wr_valid  = 1'b0;
        rd_en     = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic do_write(input int x, input int y, input int mode, input int data);
        wr_valid = 1'b1;
        wr_x = 4'(x); wr_y = 4'(y); wr_mode = 2'(mode); wr_data = 4'(data);
        tick();
        quiet();
    endtask

    task automatic do_read(input int x, input int y);
        rd_en = 1'b1;
        rd_x = 4'(x); rd_y = 4'(y);
        tick();
        quiet();
    endtask

    // Counts sweep cycles; an optional mid-sweep clr_start pulse at pulse_at.
    task automatic count_busy(input int pulse_at, output int n);
        n = 0;
        while (busy && n < 1000) begin
            clr_start = (n == pulse_at);
            rd_en = 1'b1;
            rd_x = 4'($urandom_range(0, 9));
            rd_y = 4'($urandom_range(0, 11));
            tick();
            n++;
        end
        quiet();
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) model[i] = 4'd0;

        repeat (3) tick();
        rst_n = 1'b1;
        count_busy(-1, n);
        check("reset_sweep_len", n, DEPTH);

        do_read(0, 0);
        do_read(9, 11);
        do_write(3, 5, 0, 1);
        do_read(3, 5);
        do_read(5, 3);

        do_write(0, 0, 0, 4'hA); do_read(0, 0);
        do_write(0, 0, 1, 4'h5); do_read(0, 0);
        do_write(0, 0, 2, 4'h3); do_read(0, 0);
        do_write(0, 0, 3, 4'hF); do_read(0, 0);

        // Same-cycle write and read of the last cell sees old data.
        wr_valid = 1'b1; wr_x = 4'd9; wr_y = 4'd11; wr_mode = 2'b00; wr_data = 4'd1;
        rd_en = 1'b1; rd_x = 4'd9; rd_y = 4'd11;
        tick();
        quiet();
        do_read(9, 11);

        do_write(12, 4, 0, 4'hF);
        do_read(12, 4);
        do_read(2, 5);
        do_write(3, 13, 0, 4'hF);
        do_read(3, 13);
        do_read(3, 1);

        for (int i = 0; i < 400; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_x = 4'($urandom_range(0, 15)); wr_y = 4'($urandom_range(0, 15));
            wr_mode = 2'($urandom_range(0, 3)); wr_data = 4'($urandom_range(0, 15));
            rd_en = 1'($urandom_range(0, 1));
            rd_x = 4'($urandom_range(0, 15)); rd_y = 4'($urandom_range(0, 15));
            tick();
        end
        quiet();

        // clr_start with a write in the same cycle, then a pulse mid-sweep.
        do_write(1, 1, 0, 4'h7);
        wr_valid = 1'b1; wr_x = 4'd1; wr_y = 4'd1; wr_mode = 2'b00; wr_data = 4'h6;
        clr_start = 1'b1;
        tick();
        quiet();
        count_busy(50, n);
        check("clr_sweep_len", n, DEPTH);
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) do_read(x, y);

        do_write(4, 4, 0, 4'h9);
        clr_start = 1'b1;
        tick();
        quiet();
        repeat (100) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        count_busy(-1, n);
        check("reset_mid_sweep_len", n, DEPTH);
        do_read(4, 4);
        do_read(1, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
